// File: rtl/rf_scoreboard.sv
// rf_scoreboard: parametrised bypassed register file with a per-register
// pending-write scoreboard that drives decode RAW/saturation stalls.
module rf_scoreboard #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int CNT_W    = 2,
    parameter bit ZERO_R0  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd1_sel,
    input  logic [ADDR_W-1:0] rd2_sel,
    input  logic              rd1_used,
    input  logic              rd2_used,
    output logic [WIDTH-1:0]  rd1_data,
    output logic [WIDTH-1:0]  rd2_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_sel,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              iss_valid,
    input  logic              iss_wr,
    input  logic [ADDR_W-1:0] iss_sel,
    output logic              stall,
    output logic              err_reg
);
    localparam logic [ADDR_W:0]  NREG    = NUM_REGS[ADDR_W:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0] cnt  [NUM_REGS];
    logic [WIDTH-1:0] rd1_raw, rd2_raw;
    logic [CNT_W-1:0] c1, c2, ci;
    logic             wr_ok, inc;

    function automatic logic in_range(input logic [ADDR_W-1:0] sel);
        return {1'b0, sel} < NREG;
    endfunction

    function automatic logic legal(input logic [ADDR_W-1:0] sel);
        return in_range(sel) && !(ZERO_R0 && sel == '0);
    endfunction

    // A single outstanding write landing this cycle is covered by the bypass.
    function automatic logic pend(input logic [CNT_W-1:0] c, input logic [ADDR_W-1:0] sel);
        return c != '0 && !(c == CNT_ONE && wr_ok && wr_sel == sel);
    endfunction

    always_comb begin
        rd1_raw = '0;
        rd2_raw = '0;
        c1 = '0;
        c2 = '0;
        ci = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd1_sel == ADDR_W'(i)) begin
                rd1_raw = regs[i];
                c1 = cnt[i];
            end
            if (rd2_sel == ADDR_W'(i)) begin
                rd2_raw = regs[i];
                c2 = cnt[i];
            end
            if (iss_sel == ADDR_W'(i)) ci = cnt[i];
        end
    end

    assign wr_ok    = wr_en && legal(wr_sel);
    assign rd1_data = (!rst || !legal(rd1_sel)) ? '0 : (wr_ok && wr_sel == rd1_sel) ? wr_data : rd1_raw;
    assign rd2_data = (!rst || !legal(rd2_sel)) ? '0 : (wr_ok && wr_sel == rd2_sel) ? wr_data : rd2_raw;
    assign stall    = rst && iss_valid && ((rd1_used && pend(c1, rd1_sel)) ||
                                           (rd2_used && pend(c2, rd2_sel)) ||
                                           (iss_wr && ci == CNT_MAX));
    assign err_reg  = rst && ((rd1_used && !in_range(rd1_sel)) || (rd2_used && !in_range(rd2_sel)) ||
                              (wr_en && !in_range(wr_sel)) || (iss_valid && iss_wr && !in_range(iss_sel)));
    assign inc      = iss_valid && iss_wr && !stall && legal(iss_sel);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && wr_sel == ADDR_W'(i)) regs[i] <= wr_data;
                cnt[i] <= cnt[i] + CNT_W'(inc && iss_sel == ADDR_W'(i))
                                 - CNT_W'(wr_ok && wr_sel == ADDR_W'(i) && cnt[i] != '0);
            end
        end
    end
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed scenarios plus randomized traffic checked against
// an array/counter reference model of the register file and scoreboard.
module tb_rf_scoreboard;
    localparam int W = 16;
    localparam int N = 6;
    localparam int A = 3;
    localparam int C = 2;
    localparam int SAT = (1 << C) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [A-1:0] rd1_sel, rd2_sel, wr_sel, iss_sel;
    logic         rd1_used, rd2_used, wr_en, iss_valid, iss_wr;
    logic [W-1:0] wr_data, rd1_data, rd2_data;
    logic         stall, err_reg;
    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] mem_m [8];
    int           cnt_m [8];

    always #5 clk = ~clk;

    rf_scoreboard #(.WIDTH(W), .NUM_REGS(N), .ADDR_W(A), .CNT_W(C), .ZERO_R0(1'b1)) dut (
        .clk(clk), .rst(rst),
        .rd1_sel(rd1_sel), .rd2_sel(rd2_sel), .rd1_used(rd1_used), .rd2_used(rd2_used),
        .rd1_data(rd1_data), .rd2_data(rd2_data),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_sel(iss_sel),
        .stall(stall), .err_reg(err_reg)
    );

    function automatic bit m_legal(int s);
        return s < N && s != 0;
    endfunction

    function automatic int m_cnt(int s);
        return (s < N) ? cnt_m[s] : 0;
    endfunction

    function automatic bit m_wr();
        return wr_en && m_legal(int'(wr_sel));
    endfunction

    function automatic logic [W-1:0] m_read(int s);
        if (!rst || !m_legal(s)) return '0;
        if (m_wr() && int'(wr_sel) == s) return wr_data;
        return mem_m[s];
    endfunction

    function automatic bit m_pend(int s);
        int c = m_cnt(s);
        return c != 0 && !(c == 1 && m_wr() && int'(wr_sel) == s);
    endfunction

    function automatic bit m_stall();
        return rst && iss_valid && ((rd1_used && m_pend(int'(rd1_sel))) ||
                                    (rd2_used && m_pend(int'(rd2_sel))) ||
                                    (iss_wr && m_cnt(int'(iss_sel)) == SAT));
    endfunction

    function automatic bit m_err();
        return rst && ((rd1_used && rd1_sel >= N) || (rd2_used && rd2_sel >= N) ||
                       (wr_en && wr_sel >= N) || (iss_valid && iss_wr && iss_sel >= N));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            mem_m[i] = '0;
            cnt_m[i] = 0;
        end
    endtask

    // Advance the model with the inputs currently applied, then the DUT by one clock.
    task automatic step();
        bit st;
        st = m_stall();
        if (rst) begin
            if (m_wr()) begin
                mem_m[wr_sel] = wr_data;
                if (cnt_m[wr_sel] > 0) cnt_m[wr_sel]--;
            end
            if (iss_valid && iss_wr && !st && m_legal(int'(iss_sel))) cnt_m[iss_sel]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd1_sel = '0; rd2_sel = '0; rd1_used = 0; rd2_used = 0;
        wr_en = 0; wr_sel = '0; wr_data = '0;
        iss_valid = 0; iss_wr = 0; iss_sel = '0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        m_reset();
        wr_en = 1; wr_sel = 3; wr_data = 16'h1111; rd1_sel = 3; rd1_used = 1;
        rd2_sel = 7; rd2_used = 1; iss_valid = 1; iss_wr = 1; iss_sel = 7;
        #2;
        tests++; if (rd1_data !== 16'h0) begin fails++; $display("FAIL reset_rd1 got=%h exp=0000", rd1_data); end
        tests++; if (err_reg !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err_reg); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        idle();
        @(posedge clk);
        #1;
        wr_en = 1; wr_sel = 3; wr_data = 16'hBEEF;
        step();
        idle();
        rd1_sel = 3; rd1_used = 1;
        #1;
        tests++; if (rd1_data !== 16'hBEEF) begin fails++; $display("FAIL write_r3 got=%h exp=beef", rd1_data); end
        #1;
        rst = 0;
        m_reset();
        #1;
        tests++; if (rd1_data !== 16'h0) begin fails++; $display("FAIL async_reset got=%h exp=0000", rd1_data); end
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        tests++; if (rd1_data !== 16'h0) begin fails++; $display("FAIL r3_cleared got=%h exp=0000", rd1_data); end
    endtask

    task automatic test_bypass();
        idle();
        wr_en = 1; wr_sel = 5; wr_data = 16'h1234; rd2_sel = 5;
        #1;
        tests++; if (rd2_data !== 16'h1234) begin fails++; $display("FAIL bypass got=%h exp=1234", rd2_data); end
        step();
        idle();
        rd2_sel = 5;
        #1;
        tests++; if (rd2_data !== 16'h1234) begin fails++; $display("FAIL bypass_stored got=%h exp=1234", rd2_data); end
    endtask

    task automatic test_load_use();
        idle();
        iss_valid = 1; iss_wr = 1; iss_sel = 2;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_issue got=%b exp=0", stall); end
        step();
        idle();
        iss_valid = 1; rd1_sel = 2; rd1_used = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall%0d got=%b exp=1", k, stall); end
            step();
        end
        wr_en = 1; wr_sel = 2; wr_data = 16'hABCD;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_wb_stall got=%b exp=0", stall); end
        tests++; if (rd1_data !== 16'hABCD) begin fails++; $display("FAIL lu_wb_data got=%h exp=abcd", rd1_data); end
        step();
        wr_en = 0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_after got=%b exp=0", stall); end
        idle();
    endtask

    task automatic test_saturation();
        idle();
        iss_valid = 1; iss_wr = 1; iss_sel = 4;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sat_issue%0d got=%b exp=0", k, stall); end
            step();
        end
        wr_en = 1; wr_sel = 4; wr_data = 16'h5555;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sat_full got=%b exp=1", stall); end
        step();
        wr_en = 0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sat_retry got=%b exp=0", stall); end
        step();
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sat_refull got=%b exp=1", stall); end
        idle();
        wr_en = 1; wr_sel = 4;
        repeat (3) step();
        idle();
        iss_valid = 1; rd1_sel = 4; rd1_used = 1;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sat_drained got=%b exp=0", stall); end
        idle();
    endtask

    task automatic test_range_zero();
        idle();
        rd1_sel = 7; rd1_used = 1;
        #1;
        tests++; if (err_reg !== 1'b1) begin fails++; $display("FAIL rng_rd_err got=%b exp=1", err_reg); end
        tests++; if (rd1_data !== 16'h0) begin fails++; $display("FAIL rng_rd_data got=%h exp=0000", rd1_data); end
        rd1_used = 0;
        #1;
        tests++; if (err_reg !== 1'b0) begin fails++; $display("FAIL rng_unused got=%b exp=0", err_reg); end
        idle();
        wr_en = 1; wr_sel = 6; wr_data = 16'h7777;
        #1;
        tests++; if (err_reg !== 1'b1) begin fails++; $display("FAIL rng_wr_err got=%b exp=1", err_reg); end
        step();
        idle();
        iss_valid = 1; iss_wr = 1; iss_sel = 6;
        #1;
        tests++; if (err_reg !== 1'b1) begin fails++; $display("FAIL rng_iss_err got=%b exp=1", err_reg); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rng_iss_stall got=%b exp=0", stall); end
        step();
        idle();
        wr_en = 1; wr_sel = 0; wr_data = 16'hFFFF; rd1_sel = 0;
        #1;
        tests++; if (rd1_data !== 16'h0) begin fails++; $display("FAIL r0_bypass got=%h exp=0000", rd1_data); end
        step();
        idle();
        #1;
        tests++; if (rd1_data !== 16'h0) begin fails++; $display("FAIL r0_stored got=%h exp=0000", rd1_data); end
        iss_valid = 1; iss_wr = 1; iss_sel = 0;
        step();
        idle();
        iss_valid = 1; rd1_sel = 0; rd1_used = 1;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL r0_pending got=%b exp=0", stall); end
        tests++; if (err_reg !== 1'b0) begin fails++; $display("FAIL r0_err got=%b exp=0", err_reg); end
        idle();
    endtask

    task automatic test_inc_dec();
        idle();
        iss_valid = 1; iss_wr = 1; iss_sel = 1;
        step();
        wr_en = 1; wr_sel = 1; wr_data = 16'h0101;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL incdec_stall got=%b exp=0", stall); end
        step();
        idle();
        iss_valid = 1; rd1_sel = 1; rd1_used = 1;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL incdec_still1 got=%b exp=1", stall); end
        wr_en = 1; wr_sel = 1; wr_data = 16'h0202;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL incdec_wb got=%b exp=0", stall); end
        step();
        wr_en = 0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL incdec_clear got=%b exp=0", stall); end
        tests++; if (rd1_data !== 16'h0202) begin fails++; $display("FAIL incdec_data got=%h exp=0202", rd1_data); end
        idle();
    endtask

    function automatic logic [A-1:0] rsel();
        return ($urandom_range(0, 9) == 0) ? A'($urandom_range(6, 7)) : A'($urandom_range(0, 5));
    endfunction

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rd1_sel = rsel(); rd2_sel = rsel(); wr_sel = rsel(); iss_sel = rsel();
            rd1_used = 1'($urandom); rd2_used = 1'($urandom);
            wr_en = ($urandom_range(0, 2) == 0); wr_data = W'($urandom);
            iss_valid = ($urandom_range(0, 3) != 0); iss_wr = 1'($urandom);
            #1;
            tests++; if (rd1_data !== m_read(int'(rd1_sel))) begin fails++; $display("FAIL rnd_rd1 k=%0d got=%h exp=%h", k, rd1_data, m_read(int'(rd1_sel))); end
            tests++; if (rd2_data !== m_read(int'(rd2_sel))) begin fails++; $display("FAIL rnd_rd2 k=%0d got=%h exp=%h", k, rd2_data, m_read(int'(rd2_sel))); end
            tests++; if (stall !== m_stall()) begin fails++; $display("FAIL rnd_stall k=%0d got=%b exp=%b", k, stall, m_stall()); end
            tests++; if (err_reg !== m_err()) begin fails++; $display("FAIL rnd_err k=%0d got=%b exp=%b", k, err_reg, m_err()); end
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_saturation();
        test_range_zero();
        test_inc_dec();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
